bound_xor_monitor: RTL

- Parametrised, multi-lane successor to the single-bit XOR bind target.
- Designed to be attached through a bind construct to a target whose output is expected to equal a ^ b.
- Recomputes a ^ b per lane, delays it by a configurable latency to match the target's pipeline, and compares it against the target's observed output.
- Reports per-lane mismatches, a saturating error count, a sticky error flag and the first failing lane.

---
 rtl/bound_xor_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bound_xor_monitor.sv
// bound_xor_monitor
// Checker meant to be bound onto a target whose output should equal a ^ b.
// Each lane recomputes a ^ b. The result goes through a LATENCY-deep delay
// line so it lines up with the target's pipeline. It is then compared with the
// observed output c. The checker reports per-lane mismatch pulses, a
// saturating error-event count, a sticky error flag and the lowest failing
// lane of the first error event.
//
// Optional build macro: BOUND_XOR_MON_FREEZE_EN
//   When defined, the checker stops counting and masks mismatch pulses once
//   sticky_err has set. Everything stays frozen at the first failure until
//   clear or rst.
//
// Handshake: en is a valid-only qualifier with no ready. Every cycle with en=1
// is taken into the delay line, and that sample is compared LATENCY cycles
// later. A cycle with en=0 is a bubble that travels down the line and
// produces no compare. There is no back-pressure.
module bound_xor_monitor #(
  parameter int WIDTH   = 1,
  parameter int LANES   = 1,
  parameter int LATENCY = 1,   // legal range 0..7, 0 = combinational target
  parameter int CNT_W   = 8,
  localparam int DW     = LANES * WIDTH,
  localparam int FL_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  input  logic [DW-1:0]     c,
  output logic [DW-1:0]     exp_c,
  output logic [LANES-1:0]  mismatch,
  output logic [CNT_W-1:0]  err_count,
  output logic              sticky_err,
  output logic [FL_W-1:0]   first_lane
);

`ifdef BOUND_XOR_MON_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  // Expected value and its valid flag at the moment of comparison.
  logic [DW-1:0] cmp_data;
  logic          cmp_valid;

  generate
    if (LATENCY == 0) begin : g_comb
      // The target is combinational, so it is compared in the same cycle as
      // the sample.
      assign cmp_data  = a ^ b;
      assign cmp_valid = en;
    end else begin : g_pipe
      logic [DW-1:0]      pipe_data [LATENCY];
      logic [LATENCY-1:0] pipe_valid;

      // The delay line: stage 0 captures {en, a^b} and later stages shift the pair forward.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < LATENCY; s++) begin
            pipe_data[s] <= '0;
          end
          pipe_valid <= '0;
        end else begin
          pipe_data[0]  <= a ^ b;
          pipe_valid[0] <= en;
          for (int s = 1; s < LATENCY; s++) begin
            pipe_data[s]  <= pipe_data[s-1];
            pipe_valid[s] <= pipe_valid[s-1];
          end
        end
      end

      assign cmp_data  = pipe_data[LATENCY-1];
      assign cmp_valid = pipe_valid[LATENCY-1];
    end
  endgenerate

  assign exp_c = cmp_data;

  // Raw per-lane inequality. It is meaningful only when cmp_valid is high.
  logic [LANES-1:0] lane_diff;

  // Compare each lane on its own. No carry crosses a lane boundary.
  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_diff[i] = (c[i*WIDTH +: WIDTH] != cmp_data[i*WIDTH +: WIDTH]);
    end
  end

  // In freeze builds, further hits are masked once the first error is held.
  logic             frozen;
  logic [LANES-1:0] hit;
  logic             any_hit;

  assign frozen  = FREEZE && sticky_err;
  assign hit     = (cmp_valid && !frozen) ? lane_diff : '0;
  assign any_hit = |hit;

  // Priority pick of the lowest failing lane. With one lane it is always 0.
  logic [FL_W-1:0] low_lane;

  // Scan from the top down so the lowest set bit is the one that remains.
  always_comb begin
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        low_lane = FL_W'(i);
      end
    end
  end

  // Register the mismatch vector so the pulse follows the compare cycle by one.
  // clear does not suppress the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= '0;
    end else begin
      mismatch <= hit;
    end
  end

  // Error bookkeeping. clear beats a simultaneous hit. The counter saturates
  // instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count  <= '0;
      sticky_err <= 1'b0;
      first_lane <= '0;
    end else if (any_hit) begin
      if (err_count != {CNT_W{1'b1}}) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (!sticky_err) begin
        sticky_err <= 1'b1;
        first_lane <= low_lane;
      end
    end
  end

endmodule
